// File: rtl/redstone_puller_if.sv
// Handshake bundle between the redstone_repeater output side, the puller and the
// downstream chunk sink. master = upstream/downstream environment, slave = puller.
interface redstone_puller_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);

    logic [REGISTER_SIZE-1:0] data_in;
    logic                     data_valid_in;
    logic                     consumed_out;
    logic                     ready_in;
    logic [REGISTER_SIZE-1:0] chunk_out;
    logic                     chunk_valid_out;
    logic [IDX_W-1:0]         chunk_idx_out;
    logic                     chunk_last_out;

    modport master (
        output data_in, data_valid_in, ready_in,
        input  consumed_out, chunk_out, chunk_valid_out, chunk_idx_out, chunk_last_out
    );

    modport slave (
        input  data_in, data_valid_in, ready_in,
        output consumed_out, chunk_out, chunk_valid_out, chunk_idx_out, chunk_last_out
    );
endinterface

// File: rtl/redstone_puller.sv
// Drains one BITS_IN_NUM-bit number word by word from the repeater, waiting out the
// BRAM read latency after every advance, and re-emits each word as a push pulse.
module redstone_puller #(
    parameter int BITS_IN_NUM   = 4096,
    parameter int REGISTER_SIZE = 32,
    parameter int READ_LATENCY  = 2
) (
    input logic              clk_in,
    input logic              rst_n_in,
    redstone_puller_if.slave bus
);
    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int CNT_W      = $clog2(READ_LATENCY + 2);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(READ_LATENCY + 1);

    typedef enum logic {
        WAIT,
        SETTLE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         settle_q, settle_d;
    logic [REGISTER_SIZE-1:0] chunk_d;
    logic [IDX_W-1:0]         chunk_idx_d;
    logic                     chunk_valid_d;
    logic                     chunk_last_d;
    logic                     consumed_d;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        settle_d      = settle_q;
        chunk_d       = bus.chunk_out;
        chunk_idx_d   = bus.chunk_idx_out;
        chunk_valid_d = 1'b0;
        chunk_last_d  = 1'b0;
        consumed_d    = 1'b0;

        unique case (state_q)
            WAIT: begin
                if (bus.data_valid_in && bus.ready_in) begin
                    chunk_d       = bus.data_in;
                    chunk_idx_d   = idx_q;
                    chunk_last_d  = (idx_q == LAST_IDX);
                    chunk_valid_d = 1'b1;
                    consumed_d    = 1'b1;
                    idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    settle_d      = SETTLE_LEN;
                    state_d       = SETTLE;
                end
            end
            SETTLE: begin
                // Upstream data_in is stale until the advance has passed through the BRAM.
                settle_d = settle_q - 1'b1;
                if (settle_q == CNT_W'(1)) begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q             <= WAIT;
            idx_q               <= '0;
            settle_q            <= '0;
            bus.chunk_out       <= '0;
            bus.chunk_idx_out   <= '0;
            bus.chunk_valid_out <= 1'b0;
            bus.chunk_last_out  <= 1'b0;
            bus.consumed_out    <= 1'b0;
        end else begin
            state_q             <= state_d;
            idx_q               <= idx_d;
            settle_q            <= settle_d;
            bus.chunk_out       <= chunk_d;
            bus.chunk_idx_out   <= chunk_idx_d;
            bus.chunk_valid_out <= chunk_valid_d;
            bus.chunk_last_out  <= chunk_last_d;
            bus.consumed_out    <= consumed_d;
        end
    end
endmodule

// File: tb/tb_redstone_puller.sv
// Directed bench: a 128-word puller fed by a latency-2 upstream model that shows
// 0xDEADBEEF while a read is in flight, plus a 4-word instance for index wrap.
module tb_redstone_puller;
    localparam int                  RL   = 2;
    localparam logic [31:0]         DEAD = 32'hDEADBEEF;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    bit seen_dead = 1'b0;

    redstone_puller_if #(.REGISTER_SIZE(32), .NUM_BLOCKS(128)) bus ();
    redstone_puller_if #(.REGISTER_SIZE(32), .NUM_BLOCKS(4))   wbus ();

    redstone_puller #(.BITS_IN_NUM(4096), .REGISTER_SIZE(32), .READ_LATENCY(RL)) u_dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );

    redstone_puller #(.BITS_IN_NUM(128), .REGISTER_SIZE(32), .READ_LATENCY(RL)) u_wrap (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (wbus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Upstream models: advance on a consumed pulse, garbage for RL cycles, then the next word.
    initial begin
        int ptr  = 0;
        int cnt  = 0;
        int wptr = 0;
        int wcnt = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                ptr = 0; cnt = 0; bus.data_in = '0;
                wptr = 0; wcnt = 0; wbus.data_in = '0;
            end else begin
                if (bus.consumed_out) begin
                    ptr = (ptr + 1) % 128; cnt = RL; bus.data_in = DEAD;
                end else if (cnt != 0) begin
                    if (cnt == 1) bus.data_in = 32'(ptr);
                    cnt--;
                end
                if (wbus.consumed_out) begin
                    wptr++; wcnt = RL; wbus.data_in = DEAD;
                end else if (wcnt != 0) begin
                    if (wcnt == 1) wbus.data_in = 32'(wptr);
                    wcnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (bus.chunk_out === DEAD || wbus.chunk_out === DEAD) seen_dead = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_chunk(input bit wrap, output int cycles);
        logic v;
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
            v = wrap ? wbus.chunk_valid_out : bus.chunk_valid_out;
        end while (!v && cycles < 8);
        check("chunk_seen", 32'(v), 32'd1);
    endtask

    initial begin
        int cyc;
        int pulses;

        bus.data_valid_in  = 1'b0;
        bus.ready_in       = 1'b0;
        wbus.data_valid_in = 1'b0;
        wbus.ready_in      = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_in);
        check("rst_chunk",    bus.chunk_out,              32'd0);
        check("rst_idx",      32'(bus.chunk_idx_out),     32'd0);
        check("rst_valid",    32'(bus.chunk_valid_out),   32'd0);
        check("rst_last",     32'(bus.chunk_last_out),    32'd0);
        check("rst_consumed", 32'(bus.consumed_out),      32'd0);
        rst_n_in = 1'b1;
        bus.data_valid_in = 1'b1;
        bus.ready_in      = 1'b1;

        // Full number: 128 words, 4 cycles apart, chunk_out == index
        for (int i = 0; i < 128; i++) begin
            wait_chunk(1'b0, cyc);
            check("n1_spacing",  32'(cyc),                   (i == 0) ? 32'd1 : 32'd4);
            check("n1_data",     bus.chunk_out,              32'(i));
            check("n1_idx",      32'(bus.chunk_idx_out),     32'(i));
            check("n1_last",     32'(bus.chunk_last_out),    (i == 127) ? 32'd1 : 32'd0);
            check("n1_consumed", 32'(bus.consumed_out),      32'd1);
        end

        // Refill gap: valid low for 130 cycles, nothing may be emitted
        bus.data_valid_in = 1'b0;
        pulses = 0;
        repeat (130) begin
            @(negedge clk_in);
            if (bus.chunk_valid_out || bus.consumed_out) pulses++;
        end
        check("gap_pulses", 32'(pulses), 32'd0);
        bus.data_valid_in = 1'b1;

        // Second number restarts at index 0
        for (int i = 0; i < 5; i++) begin
            wait_chunk(1'b0, cyc);
            check("n2_spacing", 32'(cyc),               (i == 0) ? 32'd1 : 32'd4);
            check("n2_data",    bus.chunk_out,          32'(i));
            check("n2_idx",     32'(bus.chunk_idx_out), 32'(i));
            check("n2_last",    32'(bus.chunk_last_out), 32'd0);
        end

        // Back-pressure: ready low for 10 cycles while waiting at index 5
        repeat (3) @(negedge clk_in);
        bus.ready_in = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (bus.chunk_valid_out || bus.consumed_out) pulses++;
        end
        check("stall_pulses", 32'(pulses), 32'd0);
        bus.ready_in = 1'b1;
        wait_chunk(1'b0, cyc);
        check("stall_resume", 32'(cyc),               32'd1);
        check("stall_idx",    32'(bus.chunk_idx_out), 32'd5);
        check("stall_data",   bus.chunk_out,          32'd5);

        // Asynchronous reset in the middle of SETTLE
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_chunk",    bus.chunk_out,            32'd0);
        check("arst_idx",      32'(bus.chunk_idx_out),   32'd0);
        check("arst_valid",    32'(bus.chunk_valid_out), 32'd0);
        check("arst_last",     32'(bus.chunk_last_out),  32'd0);
        check("arst_consumed", 32'(bus.consumed_out),    32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_chunk(1'b0, cyc);
        check("post_rst_cycles", 32'(cyc),               32'd1);
        check("post_rst_idx",    32'(bus.chunk_idx_out), 32'd0);
        check("post_rst_data",   bus.chunk_out,          32'd0);
        bus.data_valid_in = 1'b0;

        // Index wrap with four words per number
        wbus.data_valid_in = 1'b1;
        wbus.ready_in      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_chunk(1'b1, cyc);
            check("wrap_idx",  32'(wbus.chunk_idx_out),  32'(i % 4));
            check("wrap_last", 32'(wbus.chunk_last_out), (i % 4 == 3) ? 32'd1 : 32'd0);
            check("wrap_data", wbus.chunk_out,           32'(i));
        end
        wbus.data_valid_in = 1'b0;

        repeat (2) @(negedge clk_in);
        check("stale_guard", 32'(seen_dead), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
